// File: rtl/display_scan.sv
// Six-digit multiplexed 7-segment driver showing HH.MM.SS from the clock counters.
// It snapshots the counters once per frame and blinks the field that is being set.
module display_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] cnt_h,
  input  logic [5:0] cnt_m,
  input  logic [5:0] cnt_s,
  input  logic [1:0] set_sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0] GLYPH_DARK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH = 7'b0111111;

  logic [SW-1:0] scan_cnt_reg, scan_cnt_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic [2:0]    digit_reg, digit_next;
  logic          phase_reg, phase_next;
  logic          first_reg;
  logic [4:0]    snap_h_reg, snap_h_next;
  logic [5:0]    snap_m_reg, snap_m_next;
  logic [5:0]    snap_s_reg, snap_s_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic [5:0]    an_reg, an_next;

  logic tick;
  logic frame_wrap;
  logic capture;
  logic blink_wrap;

  // Scan prescaler, digit index and free-running blink timebase.
  always_comb begin
    tick          = (scan_cnt_reg == SCAN_LAST);
    scan_cnt_next = tick ? '0 : scan_cnt_reg + 1'b1;
    digit_next    = digit_reg;
    if (tick) begin
      digit_next = (digit_reg == 3'd5) ? 3'd0 : digit_reg + 3'd1;
    end
    frame_wrap     = tick && (digit_reg == 3'd5);
    blink_wrap     = (blink_cnt_reg == BLINK_LAST);
    blink_cnt_next = blink_wrap ? '0 : blink_cnt_reg + 1'b1;
    phase_next     = phase_reg ^ blink_wrap;
  end

  // Counters are sampled only at frame boundaries so a frame is never torn.
  always_comb begin
    capture     = frame_wrap || first_reg;
    snap_h_next = capture ? cnt_h : snap_h_reg;
    snap_m_next = capture ? cnt_m : snap_m_reg;
    snap_s_next = capture ? cnt_s : snap_s_reg;
  end

  // Per-field BCD split and range check, from the snapshot the next output will use.
  logic [5:0] field_val   [3];
  logic [3:0] field_tens  [3];
  logic [3:0] field_ones  [3];
  logic       field_valid [3];

  assign field_val[0] = {1'b0, snap_h_next};
  assign field_val[1] = snap_m_next;
  assign field_val[2] = snap_s_next;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_field
      localparam logic [5:0] LIMIT = (gi == 0) ? 6'd23 : 6'd59;
      assign field_valid[gi] = (field_val[gi] <= LIMIT);
      assign field_tens[gi]  = 4'(field_val[gi] / 6'd10);
      assign field_ones[gi]  = 4'(field_val[gi] % 6'd10);
    end
  endgenerate

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

  logic [1:0] field_idx;
  logic [3:0] digit_val;
  logic       digit_valid;
  logic       blank;

  // Output decode is driven by next-state values so the pins follow d one cycle after tick.
  always_comb begin
    field_idx   = digit_next[2:1];
    digit_val   = 4'd0;
    digit_valid = 1'b1;
    case (field_idx)
      2'd0: begin
        digit_val   = digit_next[0] ? field_ones[0] : field_tens[0];
        digit_valid = field_valid[0];
      end
      2'd1: begin
        digit_val   = digit_next[0] ? field_ones[1] : field_tens[1];
        digit_valid = field_valid[1];
      end
      default: begin
        digit_val   = digit_next[0] ? field_ones[2] : field_tens[2];
        digit_valid = field_valid[2];
      end
    endcase

    // set_sel codes 01/10/11 map to fields 0/1/2; 00 never matches.
    blank   = phase_next && (set_sel == (field_idx + 2'd1));
    an_next = ~(6'b100000 >> digit_next);
    if (blank) begin
      seg_next = GLYPH_DARK;
      dp_next  = 1'b1;
    end else begin
      seg_next = digit_valid ? glyph(digit_val) : GLYPH_DASH;
      dp_next  = ~((digit_next == 3'd1) || (digit_next == 3'd3));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_reg  <= '0;
      blink_cnt_reg <= '0;
      digit_reg     <= 3'd0;
      phase_reg     <= 1'b0;
      first_reg     <= 1'b1;
      snap_h_reg    <= '0;
      snap_m_reg    <= '0;
      snap_s_reg    <= '0;
      seg_reg       <= GLYPH_DARK;
      dp_reg        <= 1'b1;
      an_reg        <= 6'h3F;
    end else begin
      scan_cnt_reg  <= scan_cnt_next;
      blink_cnt_reg <= blink_cnt_next;
      digit_reg     <= digit_next;
      phase_reg     <= phase_next;
      first_reg     <= 1'b0;
      snap_h_reg    <= snap_h_next;
      snap_m_reg    <= snap_m_next;
      snap_s_reg    <= snap_s_next;
      seg_reg       <= seg_next;
      dp_reg        <= dp_next;
      an_reg        <= an_next;
    end
  end

  assign seg = seg_reg;
  assign dp  = dp_reg;
  assign an  = an_reg;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with SCAN_DIV=4, BLINK_DIV=16.
// n counts posedges since reset release; slot J is checked mid-slot at n = 4*J+2.
module tb_display_scan;

  logic       clk;
  logic       rst_n;
  logic [4:0] cnt_h;
  logic [5:0] cnt_m;
  logic [5:0] cnt_s;
  logic [1:0] set_sel;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  display_scan #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_h   (cnt_h),
    .cnt_m   (cnt_m),
    .cnt_s   (cnt_s),
    .set_sel (set_sel),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] G2 = 7'b0100100, G3 = 7'b0110000, G5 = 7'b0010010;
  localparam logic [6:0] G9 = 7'b0010000, G0 = 7'b1000000, G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000, DASH = 7'b0111111, DARK = 7'h7F;

  task automatic goto_n(input int target);
    while (n < target) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  // Observed/expected packed as {an, dp, seg}.
  task automatic chk(input string tag, input logic [5:0] e_an, input logic e_dp,
                     input logic [6:0] e_seg);
    logic [13:0] obs;
    logic [13:0] exp_v;
    obs   = {an, dp, seg};
    exp_v = {e_an, e_dp, e_seg};
    total++;
    $display("n=%0d %s an=%b dp=%b seg=%b", n, tag, an, dp, seg);
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed an=%b dp=%b seg=%b expected an=%b dp=%b seg=%b",
             tag, obs[13:8], obs[7], obs[6:0], exp_v[13:8], exp_v[7], exp_v[6:0]);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    cnt_h   = 5'd23;
    cnt_m   = 6'd59;
    cnt_s   = 6'd7;
    set_sel = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dark", 6'h3F, 1'b1, DARK);

    rst_n = 1'b1;
    n = 0;
    goto_n(1);
    chk("release_d0", 6'b011111, 1'b1, G2);

    // Frame 0: 23.59.07
    goto_n(2);  chk("f0_d0", 6'b011111, 1'b1, G2);
    goto_n(6);  chk("f0_d1", 6'b101111, 1'b0, G3);
    goto_n(10); chk("f0_d2", 6'b110111, 1'b1, G5);
    cnt_s = 6'd8;
    goto_n(14); chk("f0_d3", 6'b111011, 1'b0, G9);
    goto_n(18); chk("f0_d4", 6'b111101, 1'b1, G0);
    goto_n(22); chk("f0_d5_old", 6'b111110, 1'b1, G7);

    // Frame 1: new seconds value appears only now
    goto_n(26); chk("f1_d0", 6'b011111, 1'b1, G2);
    goto_n(46); chk("f1_d5_new", 6'b111110, 1'b1, G8);
    cnt_h = 5'd24;
    cnt_m = 6'd60;

    // Frame 2: out-of-range hour and minute show dashes
    goto_n(50); chk("f2_h_tens_dash", 6'b011111, 1'b1, DASH);
    goto_n(54); chk("f2_h_ones_dash", 6'b101111, 1'b0, DASH);
    goto_n(58); chk("f2_m_tens_dash", 6'b110111, 1'b1, DASH);
    goto_n(62); chk("f2_m_ones_dash", 6'b111011, 1'b0, DASH);
    goto_n(66); chk("f2_s_tens", 6'b111101, 1'b1, G0);
    goto_n(70); chk("f2_s_ones", 6'b111110, 1'b1, G8);
    cnt_h   = 5'd23;
    cnt_m   = 6'd59;
    set_sel = 2'b10;

    // Frame 3: minute selected; phase 0 for slots 18-19, phase 1 for 20-23
    goto_n(74); chk("f3_d0_ph0", 6'b011111, 1'b1, G2);
    goto_n(78); chk("f3_d1_ph0", 6'b101111, 1'b0, G3);
    goto_n(82); chk("f3_d2_blank", 6'b110111, 1'b1, DARK);
    goto_n(86); chk("f3_d3_blank", 6'b111011, 1'b1, DARK);
    goto_n(90); chk("f3_d4_unsel", 6'b111101, 1'b1, G0);
    goto_n(94); chk("f3_d5_unsel", 6'b111110, 1'b1, G8);

    // Frame 4: phase 0 on minute digits -> lit
    goto_n(106); chk("f4_d2_ph0_lit", 6'b110111, 1'b1, G5);
    goto_n(110); chk("f4_d3_ph0_lit", 6'b111011, 1'b0, G9);
    goto_n(118); chk("f4_d5_ph1_unsel", 6'b111110, 1'b1, G8);
    set_sel = 2'b01;
    goto_n(122); chk("f5_d0_hour_blank", 6'b011111, 1'b1, DARK);
    set_sel = 2'b00;
    goto_n(126); chk("f5_d1_sel00_ph1", 6'b101111, 1'b0, G3);

    // Reset on the edge where scan tick and blink wrap coincide (n=144)
    set_sel = 2'b10;
    goto_n(143);
    rst_n = 1'b0;
    goto_n(144);
    chk("midscan_reset_dark", 6'h3F, 1'b1, DARK);
    rst_n = 1'b1;
    n = 0;
    goto_n(1); chk("rerelease_d0", 6'b011111, 1'b1, G2);
    goto_n(6); chk("rerelease_d1", 6'b101111, 1'b0, G3);
    goto_n(10); chk("rerelease_d2_ph0", 6'b110111, 1'b1, G5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
